// File: rtl/base_vlat_en.sv
// Enable-gated storage element for one lane of the packer.
// Holds its value until i_en is asserted; clearing is done by loading zero data.
module base_vlat_en #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [0:width-1] i_d,
  output logic [0:width-1] o_q
);

  logic [0:width-1] r_q;

  always_ff @(posedge clk) begin
    if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/base_apack.sv
// Packs up to 'ways' input beats of 'width' bits into one output word.
// A word closes on the last lane or on an end-marked beat; lane 0 is the leftmost slice.
module base_apack #(
  parameter int unsigned width = 8,
  parameter int unsigned ways  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [0:width-1]      i_d,
  input  logic                  i_e,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [0:width*ways-1] o_d,
  output logic [0:ways-1]       o_m,
  output logic                  o_e
);

  if (ways < 2 || ways > 16) begin : g_bad_ways
    $error("base_apack: ways must be in 2..16");
  end

  localparam int unsigned CW = (ways > 1) ? $clog2(ways) : 1;

  logic [CW-1:0]    r_cnt;
  logic             r_ov;
  logic             r_oe;
  logic [0:ways-1]  r_m;

  logic             w_acc;
  logic             w_take;
  logic             w_close;
  logic [ways-1:0]  w_en;
  logic [0:ways-1]  w_m_nx;
  logic [0:width-1] w_ld [ways];
  logic [0:width-1] w_q  [ways];

  assign i_r     = ~r_ov | o_r;
  assign w_acc   = i_v & i_r;
  assign w_take  = r_ov & o_r;
  assign w_close = (r_cnt == CW'(ways - 1)) | i_e;

  // Consuming a word reloads every lane: zero, except lane 0 when a beat arrives alongside.
  always_comb begin
    w_en   = '0;
    w_m_nx = r_m;
    for (int unsigned k = 0; k < ways; k++) begin
      w_ld[k] = '0;
      if (reset) begin
        w_en[k]   = 1'b1;
        w_m_nx[k] = 1'b0;
      end else if (w_take) begin
        w_en[k] = 1'b1;
        if (k == 0 && w_acc) begin
          w_ld[k]   = i_d;
          w_m_nx[k] = 1'b1;
        end else begin
          w_m_nx[k] = 1'b0;
        end
      end else if (w_acc && r_cnt == CW'(k)) begin
        w_en[k]   = 1'b1;
        w_ld[k]   = i_d;
        w_m_nx[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ov  <= 1'b0;
      r_oe  <= 1'b0;
      r_m   <= '0;
    end else begin
      r_m <= w_m_nx;
      if (w_acc) r_cnt <= w_close ? '0 : r_cnt + 1'b1;
      if (w_acc && w_close) begin
        r_ov <= 1'b1;
        r_oe <= i_e;
      end else if (w_take) begin
        r_ov <= 1'b0;
        r_oe <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < ways; k++) begin : g_lane
    base_vlat_en #(.width(width)) u_lane (
      .clk  (clk),
      .i_en (w_en[k]),
      .i_d  (w_ld[k]),
      .o_q  (w_q[k])
    );
    assign o_d[k*width +: width] = w_q[k];
  end

  assign o_v = r_ov;
  assign o_e = r_oe;
  assign o_m = r_m;

endmodule

// File: doc/base_apack.md
BASE_APACK -- requirements
Module: base_apack

Interface
REQ-001 SHALL have parameter width, default 8: bits per input beat.
REQ-002 SHALL have parameter ways, default 4: input beats packed per output word; legal range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_v  input  1  input beat valid.
REQ-006 SHALL have port i_r  output  1  input beat ready.
REQ-007 SHALL have port i_d  input  [0:width-1]  input beat data.
REQ-008 SHALL have port i_e  input  1  end marker; the current beat closes the word.
REQ-009 SHALL have port o_v  output  1  packed word valid.
REQ-010 SHALL have port o_r  input  1  packed word ready.
REQ-011 SHALL have port o_d  output  [0:width*ways-1]  packed word; lane k is o_d[k*width +: width].
REQ-012 SHALL have port o_m  output  [0:ways-1]  lane-valid mask; bit k set means lane k holds a beat.
REQ-013 SHALL have port o_e  output  1  the word was closed by i_e.

Function
REQ-014 A beat SHALL transfer when i_v & i_r; a word SHALL transfer when o_v & o_r.
REQ-015 i_r SHALL equal ~o_v | o_r (combinational from o_r).
- Full throughput: a new word's lane-0 beat is accepted in the same cycle the previous word is consumed.
REQ-016 Beats SHALL fill lanes in order 0,1,..,ways-1; the first beat lands in o_d[0:width-1].
- An internal lane counter of $clog2(ways) bits tracks the fill position.
REQ-017 A word SHALL close when a beat is accepted with counter==ways-1 or with i_e=1.
REQ-018 o_v SHALL rise on the cycle after the closing beat is accepted (latency 1).
- On close, the counter SHALL return to 0.
REQ-019 While a word is open (counter>0, o_v=0), o_d and o_m SHALL show the partial contents; o_v SHALL stay 0.
REQ-020 Unfilled lanes of a closed word SHALL be zero in o_d and clear in o_m.
REQ-021 o_e SHALL be 1 only for a word closed by i_e, including when i_e coincides with counter==ways-1.
REQ-022 While o_v=1 and o_r=0: o_d, o_m and o_e SHALL hold stable and i_r SHALL be 0.
REQ-023 When o_v & o_r and no beat is accepted in the same cycle, o_v SHALL fall, o_d SHALL zero and o_m SHALL clear on the next cycle.
REQ-024 When o_v & o_r & i_v in the same cycle, the beat SHALL load lane 0 of a fresh word; the other lanes SHALL zero.
REQ-025 When ways=1 is requested, elaboration SHALL fail.
- Same applies to any other ways value outside the legal range.
REQ-026 i_d and i_e SHALL be ignored when i_v=0.

Reset
REQ-027 While reset=1, on each clock edge:
- o_v=0, o_e=0, o_m=0, o_d=0;
- counter=0;
- i_r SHALL read 1 in the cycle after reset deasserts.
REQ-028 Reset mid-word or while o_v=1 SHALL discard all partial or pending data with no output transfer.

Structure
REQ-029 No shared package SHALL be required; the lane-counter width SHALL be a local constant derived from ways.
REQ-030 Lane storage SHALL use one base_vlat_en instance per lane, enabled by that lane's load strobe.
- Lane data SHALL be cleared via a zero data path, not via the latch reset.
REQ-031 Control SHALL be one counter plus the o_v/o_e flops; no further sub-module.

Verification (width=8, ways=4)
REQ-032 Beats 0x11,0x22,0x33,0x44 back-to-back, o_r=1 -> one cycle after the 4th beat: o_v=1, o_d=0x11223344, o_m=1111, o_e=0.
REQ-033 Beats 0xAA, then 0xBB with i_e=1 -> o_d=0xAABB0000, o_m=1100, o_e=1.
REQ-034 Closed word, then o_r=0 for 5 cycles -> i_r=0 and o_d stable throughout; o_r=1 with i_v=1, i_d=0x55 -> next cycle o_v=0, o_m=1000, o_d=0x55000000.
REQ-035 Single beat 0x7F with i_e=1 -> o_d=0x7F000000, o_m=1000, o_e=1.
REQ-036 Two beats accepted, then reset for 1 cycle, then 0x01..0x04 -> o_d=0x01020304, o_m=1111; no earlier word emitted.
REQ-037 8 consecutive beats 0x00..0x07 with o_r=1 -> two words 0x00010203 and 0x04050607; i_r never 0.
